in_fifo_rd_drain: RTL

- Read-side consumer of the PHY input FIFO (4x8 array mode).
- Tracks outstanding read bursts issued by the memory controller and pops the FIFO only when data is owed.
- Assembles each popped entry (all byte lanes) into one beat and delivers it on a valid/ready stream with burst-last marking.
- Sits between the IN_FIFO read port and the controller read-data path, all in the FIFO read clock domain.

---
 rtl/in_fifo_rd_drain_if.sv | 27 ++
 rtl/in_fifo_rd_drain.sv | 116 +++++++++++
 2 files changed

// File: rtl/in_fifo_rd_drain_if.sv
// Read-drain bus: command handshake, IN_FIFO read port and beat stream.
// master is the drain's own view; slave is the controller/FIFO side.
interface in_fifo_rd_drain_if #(
    parameter int unsigned NUM_LANES = 8
) ();
    localparam int unsigned DW = 8 * NUM_LANES;

    logic          CMD_VALID;
    logic          CMD_READY;
    logic          FIFO_EMPTY;
    logic [DW-1:0] FIFO_Q;
    logic          FIFO_RDEN;
    logic [DW-1:0] DOUT;
    logic          DOUT_VALID;
    logic          DOUT_LAST;
    logic          DOUT_READY;

    modport master (
        input  CMD_VALID, FIFO_EMPTY, FIFO_Q, DOUT_READY,
        output CMD_READY, FIFO_RDEN, DOUT, DOUT_VALID, DOUT_LAST
    );

    modport slave (
        output CMD_VALID, FIFO_EMPTY, FIFO_Q, DOUT_READY,
        input  CMD_READY, FIFO_RDEN, DOUT, DOUT_VALID, DOUT_LAST
    );
endinterface

// File: rtl/in_fifo_rd_drain.sv
// Pops the PHY input FIFO only for beats owed to accepted read bursts and
// streams each entry out through a 2-entry skid buffer with burst-last marking.
module in_fifo_rd_drain #(
    parameter int unsigned NUM_LANES       = 8,
    parameter int unsigned BURST_BEATS     = 2,
    parameter int unsigned MAX_OUTSTANDING = 15,
    parameter int unsigned TIMEOUT         = 64
) (
    input  logic                       RDCLK,
    input  logic                       RESET,
    in_fifo_rd_drain_if.master         bus,
    output logic [3:0]                 OUTSTANDING,
    output logic                       TIMEOUT_ERR
);
    localparam int unsigned DW = 8 * NUM_LANES;
    localparam int unsigned BW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam int unsigned OW = 8;
    localparam int unsigned IW = 8;

    logic [BW-1:0] beat_cnt;
    logic          inflight;
    logic          inflight_last;
    logic [DW-1:0] skid_data;
    logic          skid_last;
    logic          skid_valid;
    logic [IW-1:0] idle_cnt;

    logic [OW-1:0] owed;
    logic [2:0]    occ_inflight;
    logic          beat_is_last;
    logic          pop;
    logic          cmd_acc;
    logic          burst_done;
    logic          rden;

    assign beat_is_last = (beat_cnt == BW'(BURST_BEATS - 1));
    assign pop          = bus.DOUT_VALID && bus.DOUT_READY;
    assign cmd_acc      = bus.CMD_VALID && bus.CMD_READY;
    assign burst_done   = rden && beat_is_last;

    // beat_cnt advances on the enable itself, so owed already excludes reads in flight
    assign owed         = OW'(OUTSTANDING) * OW'(BURST_BEATS) - OW'(beat_cnt);
    assign occ_inflight = 3'(bus.DOUT_VALID) + 3'(skid_valid) + 3'(inflight);
    assign rden         = !bus.FIFO_EMPTY && (owed != '0) && (occ_inflight < 3'(2) + 3'(pop));

    assign bus.FIFO_RDEN = rden;
    assign bus.CMD_READY = (OUTSTANDING < 4'(MAX_OUTSTANDING));

    always_ff @(posedge RDCLK) begin
        if (RESET) begin
            beat_cnt       <= '0;
            inflight       <= 1'b0;
            inflight_last  <= 1'b0;
            OUTSTANDING    <= '0;
            idle_cnt       <= '0;
            TIMEOUT_ERR    <= 1'b0;
            bus.DOUT       <= '0;
            bus.DOUT_VALID <= 1'b0;
            bus.DOUT_LAST  <= 1'b0;
            skid_data      <= '0;
            skid_last      <= 1'b0;
            skid_valid     <= 1'b0;
        end else begin
            if (rden) begin
                beat_cnt <= beat_is_last ? '0 : beat_cnt + BW'(1);
            end
            inflight      <= rden;
            inflight_last <= burst_done;

            if (cmd_acc && !burst_done) begin
                OUTSTANDING <= OUTSTANDING + 4'd1;
            end else if (!cmd_acc && burst_done) begin
                OUTSTANDING <= OUTSTANDING - 4'd1;
            end

            // idle watchdog: saturates, error flag is sticky
            if (rden || (OUTSTANDING == '0)) begin
                idle_cnt <= '0;
            end else if (idle_cnt < IW'(TIMEOUT)) begin
                idle_cnt <= idle_cnt + IW'(1);
                if (idle_cnt == IW'(TIMEOUT - 1)) begin
                    TIMEOUT_ERR <= 1'b1;
                end
            end

            // skid buffer: head is the registered output, skid catches the overflow
            if (pop) begin
                if (skid_valid) begin
                    bus.DOUT      <= skid_data;
                    bus.DOUT_LAST <= skid_last;
                    skid_valid    <= inflight;
                    if (inflight) begin
                        skid_data <= bus.FIFO_Q;
                        skid_last <= inflight_last;
                    end
                end else begin
                    bus.DOUT_VALID <= inflight;
                    if (inflight) begin
                        bus.DOUT      <= bus.FIFO_Q;
                        bus.DOUT_LAST <= inflight_last;
                    end
                end
            end else if (inflight) begin
                if (!bus.DOUT_VALID) begin
                    bus.DOUT       <= bus.FIFO_Q;
                    bus.DOUT_LAST  <= inflight_last;
                    bus.DOUT_VALID <= 1'b1;
                end else begin
                    skid_data  <= bus.FIFO_Q;
                    skid_last  <= inflight_last;
                    skid_valid <= 1'b1;
                end
            end
        end
    end
endmodule
